// File: rtl/sump_cmd_decoder.sv
// SUMP command decoder: short commands and 4-byte payload commands.
// Optional payload inter-byte timeout enabled by SUMP_CMD_TIMEOUT_EN.
module sump_cmd_decoder #(
  parameter int SAMPLE_WIDTH   = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                    system_clock,
  input  logic                    ext_reset_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    cmd_reset,
  output logic                    cmd_arm,
  output logic                    cmd_query_meta,
  output logic                    cmd_query_id,
  output logic [23:0]             cfg_divider,
  output logic                    cfg_divider_wr,
  output logic [15:0]             cfg_read_count,
  output logic [15:0]             cfg_delay_count,
  output logic                    cfg_count_wr,
  output logic [SAMPLE_WIDTH-1:0] trig_rise_mask,
  output logic [SAMPLE_WIDTH-1:0] trig_fall_mask,
  output logic                    trig_wr,
  output logic                    busy,
  output logic                    cmd_unknown,
  output logic                    cmd_abort
);

  typedef enum logic {IDLE, PAYLOAD} state_e;

  state_e state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] op_q, op_d;
  logic [7:0] b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
  logic [23:0] div_q, div_d;
  logic [15:0] rd_q, rd_d, dly_q, dly_d;
  logic [SAMPLE_WIDTH-1:0] rise_q, rise_d, fall_q, fall_d;
  logic rst_s_q, rst_s_d, arm_q, arm_d;
  logic meta_q, meta_d, id_q, id_d;
  logic div_wr_q, div_wr_d, cnt_wr_q, cnt_wr_d;
  logic trig_wr_q, trig_wr_d, unk_q, unk_d;

`ifdef SUMP_CMD_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic abort_q, abort_d;
`else
  logic tmo_unused;
  assign tmo_unused = (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    op_d      = op_q;
    b0_d      = b0_q;
    b1_d      = b1_q;
    b2_d      = b2_q;
    div_d     = div_q;
    rd_d      = rd_q;
    dly_d     = dly_q;
    rise_d    = rise_q;
    fall_d    = fall_q;
    rst_s_d   = 1'b0;
    arm_d     = 1'b0;
    meta_d    = 1'b0;
    id_d      = 1'b0;
    div_wr_d  = 1'b0;
    cnt_wr_d  = 1'b0;
    trig_wr_d = 1'b0;
    unk_d     = 1'b0;
`ifdef SUMP_CMD_TIMEOUT_EN
    tmo_d     = tmo_q;
    abort_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data[7]) begin
            op_d    = rx_data;
            idx_d   = 2'd0;
            state_d = PAYLOAD;
`ifdef SUMP_CMD_TIMEOUT_EN
            tmo_d   = LOAD;
`endif
          end else begin
            unique case (rx_data)
              8'h00:   rst_s_d = 1'b1;
              8'h01:   arm_d   = 1'b1;
              8'h02:   meta_d  = 1'b1;
              8'h04:   id_d    = 1'b1;
              default: unk_d   = 1'b1;
            endcase
          end
        end
      end
      PAYLOAD: begin
        if (rx_valid) begin
          idx_d = idx_q + 2'd1;
`ifdef SUMP_CMD_TIMEOUT_EN
          tmo_d = LOAD;
`endif
          unique case (idx_q)
            2'd0: b0_d = rx_data;
            2'd1: b1_d = rx_data;
            2'd2: b2_d = rx_data;
            2'd3: begin
              // Final byte is used straight from rx_data
              state_d = IDLE;
              unique case (op_q)
                8'h80: begin
                  div_d    = {b1_q, b2_q, rx_data};
                  div_wr_d = 1'b1;
                end
                8'h81: begin
                  rd_d     = {b0_q, b1_q};
                  dly_d    = {b2_q, rx_data};
                  cnt_wr_d = 1'b1;
                end
                8'hC1: begin
                  fall_d    = b2_q[SAMPLE_WIDTH-1:0];
                  rise_d    = rx_data[SAMPLE_WIDTH-1:0];
                  trig_wr_d = 1'b1;
                end
                default: unk_d = 1'b1;
              endcase
            end
          endcase
        end
`ifdef SUMP_CMD_TIMEOUT_EN
        else if (tmo_q == '0) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end else begin
          tmo_d = tmo_q - CNT_W'(1);
        end
`endif
      end
    endcase
  end

  always_ff @(posedge system_clock) begin
    if (!ext_reset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      op_q      <= '0;
      b0_q      <= '0;
      b1_q      <= '0;
      b2_q      <= '0;
      div_q     <= '0;
      rd_q      <= '0;
      dly_q     <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      rst_s_q   <= 1'b0;
      arm_q     <= 1'b0;
      meta_q    <= 1'b0;
      id_q      <= 1'b0;
      div_wr_q  <= 1'b0;
      cnt_wr_q  <= 1'b0;
      trig_wr_q <= 1'b0;
      unk_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      op_q      <= op_d;
      b0_q      <= b0_d;
      b1_q      <= b1_d;
      b2_q      <= b2_d;
      div_q     <= div_d;
      rd_q      <= rd_d;
      dly_q     <= dly_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      rst_s_q   <= rst_s_d;
      arm_q     <= arm_d;
      meta_q    <= meta_d;
      id_q      <= id_d;
      div_wr_q  <= div_wr_d;
      cnt_wr_q  <= cnt_wr_d;
      trig_wr_q <= trig_wr_d;
      unk_q     <= unk_d;
    end
  end

`ifdef SUMP_CMD_TIMEOUT_EN
  always_ff @(posedge system_clock) begin
    if (!ext_reset_n) begin
      tmo_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      tmo_q   <= tmo_d;
      abort_q <= abort_d;
    end
  end
  assign cmd_abort = abort_q;
`else
  assign cmd_abort = 1'b0;
`endif

  assign busy            = (state_q == PAYLOAD);
  assign cmd_reset       = rst_s_q;
  assign cmd_arm         = arm_q;
  assign cmd_query_meta  = meta_q;
  assign cmd_query_id    = id_q;
  assign cfg_divider     = div_q;
  assign cfg_divider_wr  = div_wr_q;
  assign cfg_read_count  = rd_q;
  assign cfg_delay_count = dly_q;
  assign cfg_count_wr    = cnt_wr_q;
  assign trig_rise_mask  = rise_q;
  assign trig_fall_mask  = fall_q;
  assign trig_wr         = trig_wr_q;
  assign cmd_unknown     = unk_q;

endmodule

// File: tb/tb_sump_cmd_decoder.sv
// Self-checking bench for sump_cmd_decoder against a message-level model.
// Timeout scenario runs only when SUMP_CMD_TIMEOUT_EN is defined.
module tb_sump_cmd_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic rx_valid = 1'b0;
  logic cmd_reset, cmd_arm, cmd_query_meta, cmd_query_id;
  logic [23:0] cfg_divider;
  logic cfg_divider_wr;
  logic [15:0] cfg_read_count, cfg_delay_count;
  logic cfg_count_wr;
  logic [7:0] trig_rise_mask, trig_fall_mask;
  logic trig_wr, busy, cmd_unknown, cmd_abort;

  sump_cmd_decoder #(.SAMPLE_WIDTH(8), .TIMEOUT_CYCLES(100)) dut (
    .system_clock    (clk),
    .ext_reset_n     (rst_n),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .cmd_reset       (cmd_reset),
    .cmd_arm         (cmd_arm),
    .cmd_query_meta  (cmd_query_meta),
    .cmd_query_id    (cmd_query_id),
    .cfg_divider     (cfg_divider),
    .cfg_divider_wr  (cfg_divider_wr),
    .cfg_read_count  (cfg_read_count),
    .cfg_delay_count (cfg_delay_count),
    .cfg_count_wr    (cfg_count_wr),
    .trig_rise_mask  (trig_rise_mask),
    .trig_fall_mask  (trig_fall_mask),
    .trig_wr         (trig_wr),
    .busy            (busy),
    .cmd_unknown     (cmd_unknown),
    .cmd_abort       (cmd_abort)
  );

  always #5 clk = ~clk;

  // {abort, reset, arm, meta, id, div_wr, count_wr, trig_wr, unknown}
  logic [8:0] strb;
  logic [71:0] cfgv;
  assign strb = {cmd_abort, cmd_reset, cmd_arm, cmd_query_meta,
                 cmd_query_id, cfg_divider_wr, cfg_count_wr,
                 trig_wr, cmd_unknown};
  assign cfgv = {cfg_divider, cfg_read_count, cfg_delay_count,
                 trig_rise_mask, trig_fall_mask};

  int n_chk = 0;
  int n_pass = 0;

  // Message-level reference model
  bit m_long = 1'b0;
  logic [7:0] m_q[$];
  logic [8:0] e_strb = '0;
  logic [23:0] e_div = '0;
  logic [15:0] e_rd = '0, e_dly = '0;
  logic [7:0] e_rise = '0, e_fall = '0;

  function automatic logic [71:0] e_cfg();
    return {e_div, e_rd, e_dly, e_rise, e_fall};
  endfunction

  task automatic mdl_clear();
    m_long = 1'b0;
    m_q.delete();
    e_strb = '0;
    e_div = '0;
    e_rd = '0;
    e_dly = '0;
    e_rise = '0;
    e_fall = '0;
  endtask

  task automatic mdl(input logic [7:0] b);
    e_strb = '0;
    if (!m_long) begin
      if (b[7]) begin
        m_long = 1'b1;
        m_q.delete();
        m_q.push_back(b);
      end else begin
        case (b)
          8'h00: e_strb[7] = 1'b1;
          8'h01: e_strb[6] = 1'b1;
          8'h02: e_strb[5] = 1'b1;
          8'h04: e_strb[4] = 1'b1;
          default: e_strb[0] = 1'b1;
        endcase
      end
    end else begin
      m_q.push_back(b);
      if (m_q.size() == 5) begin
        m_long = 1'b0;
        case (m_q[0])
          8'h80: begin
            e_div = {m_q[2], m_q[3], m_q[4]};
            e_strb[3] = 1'b1;
          end
          8'h81: begin
            e_rd = {m_q[1], m_q[2]};
            e_dly = {m_q[3], m_q[4]};
            e_strb[2] = 1'b1;
          end
          8'hC1: begin
            e_fall = m_q[3];
            e_rise = m_q[4];
            e_strb[1] = 1'b1;
          end
          default: e_strb[0] = 1'b1;
        endcase
      end
    end
  endtask

  task automatic put(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    mdl(b);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx_data = 8'h80;
    rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if (strb !== 9'h0) $display("FAIL rst_strb got %h exp 000", strb);
    else n_pass++;
    n_chk++;
    if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy);
    else n_pass++;
    n_chk++;
    if (cfgv !== 72'h0) $display("FAIL rst_cfg got %h exp 0", cfgv);
    else n_pass++;
    rst_n = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0) $display("FAIL rst_ignore got %b exp 0", busy);
    else n_pass++;
    mdl_clear();
  endtask

  task automatic test_short_cmds();
    logic [7:0] cmds [4] = '{8'h00, 8'h01, 8'h02, 8'h04};
    logic [8:0] want [4] = '{9'h080, 9'h040, 9'h020, 9'h010};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      put(cmds[i]);
      @(negedge clk);
      rx_valid = 1'b0;
      n_chk++;
      if (strb !== want[i] || strb !== e_strb)
        $display("FAIL short_%0d got %h exp %h", i, strb, want[i]);
      else n_pass++;
      @(negedge clk);
      n_chk++;
      if (strb !== 9'h0) $display("FAIL short_width_%0d got %h exp 000", i, strb);
      else n_pass++;
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic test_divider();
    logic [7:0] s [5] = '{8'h80, 8'h00, 8'h00, 8'h01, 8'hF3};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      put(s[i]);
      @(negedge clk);
      rx_valid = 1'b0;
      n_chk++;
      if (strb !== e_strb) $display("FAIL div_strb_%0d got %h exp %h", i, strb, e_strb);
      else n_pass++;
      n_chk++;
      if (busy !== (i < 4)) $display("FAIL div_busy_%0d got %b exp %b", i, busy, i < 4);
      else n_pass++;
    end
    n_chk++;
    if (cfg_divider !== 24'h0001F3) $display("FAIL div_val got %h exp 0001f3", cfg_divider);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (strb !== 9'h0) $display("FAIL div_width got %h exp 000", strb);
    else n_pass++;
  endtask

  task automatic test_counts_trig();
    logic [7:0] s [10] = '{8'h81, 8'h00, 8'h18, 8'h00, 8'h18,
                           8'hC1, 8'h00, 8'h00, 8'h00, 8'h01};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      put(s[i]);
      @(negedge clk);
      rx_valid = 1'b0;
      n_chk++;
      if (strb !== e_strb) $display("FAIL ct_strb_%0d got %h exp %h", i, strb, e_strb);
      else n_pass++;
      n_chk++;
      if (cfgv !== e_cfg()) $display("FAIL ct_cfg_%0d got %h exp %h", i, cfgv, e_cfg());
      else n_pass++;
    end
    n_chk++;
    if ({cfg_read_count, cfg_delay_count} !== 32'h0018_0018)
      $display("FAIL ct_counts got %h exp 00180018", {cfg_read_count, cfg_delay_count});
    else n_pass++;
    n_chk++;
    if ({trig_fall_mask, trig_rise_mask} !== 16'h0001)
      $display("FAIL ct_masks got %h exp 0001", {trig_fall_mask, trig_rise_mask});
    else n_pass++;
  endtask

  task automatic test_zero_payload();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      put(i == 0 ? 8'h80 : 8'h00);
      @(negedge clk);
      rx_valid = 1'b0;
      n_chk++;
      if (strb !== e_strb) $display("FAIL zero_strb_%0d got %h exp %h", i, strb, e_strb);
      else n_pass++;
    end
    n_chk++;
    if (cfg_divider !== 24'h0) $display("FAIL zero_div got %h exp 0", cfg_divider);
    else n_pass++;
  endtask

  task automatic test_unknown_and_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      put(i == 0 ? 8'h90 : 8'($urandom));
      @(negedge clk);
      rx_valid = 1'b0;
      n_chk++;
      if (strb !== e_strb) $display("FAIL unk_strb_%0d got %h exp %h", i, strb, e_strb);
      else n_pass++;
    end
    n_chk++;
    if (cfgv !== e_cfg()) $display("FAIL unk_cfg got %h exp %h", cfgv, e_cfg());
    else n_pass++;
    @(negedge clk);
    put(8'h81);
    @(negedge clk);
    put(8'h12);
    @(negedge clk);
    rst_n = 1'b0;
    rx_data = 8'h55;
    @(negedge clk);
    rst_n = 1'b1;
    rx_valid = 1'b0;
    mdl_clear();
    n_chk++;
    if (strb !== 9'h0) $display("FAIL prst_strb got %h exp 000", strb);
    else n_pass++;
    n_chk++;
    if (busy !== 1'b0) $display("FAIL prst_busy got %b exp 0", busy);
    else n_pass++;
    n_chk++;
    if (cfgv !== 72'h0) $display("FAIL prst_cfg got %h exp 0", cfgv);
    else n_pass++;
    put(8'h01);
    @(negedge clk);
    rx_valid = 1'b0;
    n_chk++;
    if (strb !== 9'h040) $display("FAIL prst_arm got %h exp 040", strb);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] s [12] = '{8'hC1, 8'hA5, 8'h3C, 8'h7E, 8'h81, 8'h02,
                           8'h81, 8'h12, 8'h34, 8'h56, 8'h78, 8'h04};
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_chk++;
        if (strb !== e_strb) $display("FAIL b2b_strb_%0d got %h exp %h", i, strb, e_strb);
        else n_pass++;
        n_chk++;
        if (busy !== m_long) $display("FAIL b2b_busy_%0d got %b exp %b", i, busy, m_long);
        else n_pass++;
        n_chk++;
        if (cfgv !== e_cfg()) $display("FAIL b2b_cfg_%0d got %h exp %h", i, cfgv, e_cfg());
        else n_pass++;
      end
      if (i < 12) put(s[i]);
      else rx_valid = 1'b0;
    end
  endtask

  task automatic test_random();
    logic [7:0] ops [4] = '{8'h80, 8'h81, 8'hC1, 8'hA7};
    logic [7:0] b;
    for (int i = 0; i <= 600; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_chk++;
        if (strb !== e_strb) $display("FAIL rnd_strb_%0d got %h exp %h", i, strb, e_strb);
        else n_pass++;
        n_chk++;
        if (busy !== m_long) $display("FAIL rnd_busy_%0d got %b exp %b", i, busy, m_long);
        else n_pass++;
        n_chk++;
        if (cfgv !== e_cfg()) $display("FAIL rnd_cfg_%0d got %h exp %h", i, cfgv, e_cfg());
        else n_pass++;
      end
      if (i == 600 || $urandom_range(0, 3) == 0) begin
        rx_valid = 1'b0;
        e_strb = '0;
      end else begin
        if (!m_long && $urandom_range(0, 2) == 0) b = ops[$urandom_range(0, 3)];
        else if (!m_long) b = 8'($urandom_range(0, 5));
        else b = 8'($urandom);
        put(b);
      end
    end
  endtask

`ifdef SUMP_CMD_TIMEOUT_EN
  task automatic test_timeout();
    bit early = 1'b0;
    @(negedge clk);
    put(8'h80);
    @(negedge clk);
    put(8'h00);
    @(negedge clk);
    rx_valid = 1'b0;
    for (int k = 1; k < 100; k++) begin
      @(negedge clk);
      if (cmd_abort !== 1'b0 || busy !== 1'b1) early = 1'b1;
    end
    n_chk++;
    if (early) $display("FAIL tmo_early got abort before 100 idle cycles exp none");
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if ({cmd_abort, busy} !== 2'b10)
      $display("FAIL tmo_abort got %b exp 10", {cmd_abort, busy});
    else n_pass++;
    m_long = 1'b0;
    m_q.delete();
    n_chk++;
    if (cfgv !== e_cfg()) $display("FAIL tmo_cfg got %h exp %h", cfgv, e_cfg());
    else n_pass++;
    put(8'h01);
    @(negedge clk);
    rx_valid = 1'b0;
    n_chk++;
    if (strb !== 9'h040) $display("FAIL tmo_arm got %h exp 040", strb);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_short_cmds();
    test_divider();
    test_counts_trig();
    test_zero_payload();
    test_unknown_and_reset();
    test_back_to_back();
    test_random();
`ifdef SUMP_CMD_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
